// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//            driving a shared-ALU, single-memory datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int ENABLE_SYSTEM = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [6:0] iOpcode,
    input  logic       iMemAck,
    input  logic       iTrapClr,
    output logic       oMemReq,
    output logic       oMemRd,
    output logic       oMemWr,
    output logic       oIrWrite,
    output logic       oPcWrite,
    output logic       oPcSrc,
    output logic [2:0] oAluOp,
    output logic       oAluSrc1,
    output logic       oAluSrc2,
    output logic       oLui,
    output logic       oMemtoReg,
    output logic       oRegWrite,
    output logic       oBranch,
    output logic       oJump,
    output logic       oIllegal,
    output logic       oBusErr,
    output logic       oEcall,
    output logic [2:0] oState
);

    localparam logic [6:0] c_opRType  = 7'b0110011;
    localparam logic [6:0] c_opIType  = 7'b0010011;
    localparam logic [6:0] c_opLoad   = 7'b0000011;
    localparam logic [6:0] c_opStore  = 7'b0100011;
    localparam logic [6:0] c_opBranch = 7'b1100011;
    localparam logic [6:0] c_opLui    = 7'b0110111;
    localparam logic [6:0] c_opAuipc  = 7'b0010111;
    localparam logic [6:0] c_opJal    = 7'b1101111;
    localparam logic [6:0] c_opJalr   = 7'b1100111;
    localparam logic [6:0] c_opSystem = 7'b1110011;

    localparam logic [2:0] c_aluAdd    = 3'b000;
    localparam logic [2:0] c_aluBranch = 3'b001;
    localparam logic [2:0] c_aluRType  = 3'b010;
    localparam logic [2:0] c_aluIType  = 3'b011;

    localparam int c_cntWidth = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_cntWidth-1:0] c_waitLast =
        c_cntWidth'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        stFetch  = 3'd0,
        stDecode = 3'd1,
        stExec   = 3'd2,
        stMem    = 3'd3,
        stWb     = 3'd4,
        stTrap   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [6:0]            r_opcode;
    logic [c_cntWidth-1:0] r_waitCnt;
    logic [c_cntWidth-1:0] w_waitNext;
    logic                  r_illegal;
    logic                  r_busErr;
    logic                  r_ecall;
    logic                  w_setIllegal;
    logic                  w_setBusErr;
    logic                  w_setEcall;
    logic                  w_waitExpired;
    logic                  w_inKnown;
    logic                  w_inSystem;
    logic                  w_isLoad;
    logic                  w_isStore;
    logic                  w_isBranch;
    logic                  w_isJump;

    // Opcode classes: incoming opcode for the DECODE decision, latched one afterwards
    assign w_inKnown = (iOpcode == c_opRType)  || (iOpcode == c_opIType) ||
                       (iOpcode == c_opLoad)   || (iOpcode == c_opStore) ||
                       (iOpcode == c_opBranch) || (iOpcode == c_opLui)   ||
                       (iOpcode == c_opAuipc)  || (iOpcode == c_opJal)   ||
                       (iOpcode == c_opJalr);
    assign w_inSystem = (ENABLE_SYSTEM != 0) && (iOpcode == c_opSystem);

    assign w_isLoad   = (r_opcode == c_opLoad);
    assign w_isStore  = (r_opcode == c_opStore);
    assign w_isBranch = (r_opcode == c_opBranch);
    assign w_isJump   = (r_opcode == c_opJal) || (r_opcode == c_opJalr);

    generate
        if (MEM_TIMEOUT != 0) begin : g_timeout
            assign w_waitExpired = (r_waitCnt == c_waitLast);
        end else begin : g_noTimeout
            assign w_waitExpired = 1'b0;
        end
    endgenerate

    always_comb begin
        w_nextState  = r_state;
        w_setIllegal = 1'b0;
        w_setBusErr  = 1'b0;
        w_setEcall   = 1'b0;
        unique case (r_state)
            stFetch: begin
                // An ack on the final allowed cycle beats the timeout
                if (iMemAck) begin
                    w_nextState = stDecode;
                end else if (w_waitExpired) begin
                    w_nextState = stTrap;
                    w_setBusErr = 1'b1;
                end
            end
            stDecode: begin
                if (w_inKnown) begin
                    w_nextState = stExec;
                end else if (w_inSystem) begin
                    w_nextState = stTrap;
                    w_setEcall  = 1'b1;
                end else begin
                    w_nextState  = stTrap;
                    w_setIllegal = 1'b1;
                end
            end
            stExec: begin
                if (w_isLoad || w_isStore) begin
                    w_nextState = stMem;
                end else if (w_isBranch) begin
                    w_nextState = stFetch;
                end else begin
                    w_nextState = stWb;
                end
            end
            stMem: begin
                if (iMemAck) begin
                    w_nextState = w_isLoad ? stWb : stFetch;
                end else if (w_waitExpired) begin
                    w_nextState = stTrap;
                    w_setBusErr = 1'b1;
                end
            end
            stWb: begin
                w_nextState = stFetch;
            end
            stTrap: begin
                if (iTrapClr) begin
                    w_nextState = stFetch;
                end
            end
            default: begin
                w_nextState = stFetch;
            end
        endcase
    end

    // Wait counter runs only while parked in a memory phase
    assign w_waitNext = ((w_nextState == r_state) &&
                         ((r_state == stFetch) || (r_state == stMem)))
                        ? (r_waitCnt + 1'b1) : '0;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state   <= stFetch;
            r_opcode  <= '0;
            r_waitCnt <= '0;
            r_illegal <= 1'b0;
            r_busErr  <= 1'b0;
            r_ecall   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_waitNext;
            if (r_state == stDecode) begin
                r_opcode <= iOpcode;
            end
            if ((r_state == stTrap) && iTrapClr) begin
                r_illegal <= 1'b0;
                r_busErr  <= 1'b0;
                r_ecall   <= 1'b0;
            end else begin
                r_illegal <= r_illegal | w_setIllegal;
                r_busErr  <= r_busErr  | w_setBusErr;
                r_ecall   <= r_ecall   | w_setEcall;
            end
        end
    end

    always_comb begin
        oMemReq   = 1'b0;
        oMemRd    = 1'b0;
        oMemWr    = 1'b0;
        oIrWrite  = 1'b0;
        oPcWrite  = 1'b0;
        oPcSrc    = 1'b0;
        oAluOp    = c_aluAdd;
        oAluSrc1  = 1'b0;
        oAluSrc2  = 1'b0;
        oLui      = 1'b0;
        oMemtoReg = 1'b0;
        oRegWrite = 1'b0;
        oBranch   = 1'b0;
        oJump     = 1'b0;
        unique case (r_state)
            stFetch: begin
                oMemReq  = 1'b1;
                oMemRd   = 1'b1;
                oIrWrite = iMemAck;
                oPcWrite = iMemAck;
            end
            stExec: begin
                unique case (r_opcode)
                    c_opRType: oAluOp = c_aluRType;
                    c_opIType: begin
                        oAluOp   = c_aluIType;
                        oAluSrc2 = 1'b1;
                    end
                    c_opLoad, c_opStore: oAluSrc2 = 1'b1;
                    c_opBranch: begin
                        oAluOp   = c_aluBranch;
                        oBranch  = 1'b1;
                        oPcSrc   = 1'b1;
                        oPcWrite = 1'b1;
                    end
                    c_opLui: begin
                        oLui     = 1'b1;
                        oAluSrc2 = 1'b1;
                    end
                    c_opAuipc: begin
                        oAluSrc1 = 1'b1;
                        oAluSrc2 = 1'b1;
                    end
                    c_opJal: begin
                        oAluSrc1 = 1'b1;
                        oAluSrc2 = 1'b1;
                        oJump    = 1'b1;
                    end
                    c_opJalr: begin
                        oAluSrc2 = 1'b1;
                        oJump    = 1'b1;
                    end
                    default: begin
                        oAluOp = c_aluAdd;
                    end
                endcase
            end
            stMem: begin
                oMemReq  = 1'b1;
                oMemRd   = w_isLoad;
                oMemWr   = w_isStore;
                oAluSrc2 = 1'b1;
            end
            stWb: begin
                // Jumps write the link and redirect the PC in this same cycle
                oRegWrite = 1'b1;
                oMemtoReg = w_isLoad;
                oJump     = w_isJump;
                oPcSrc    = w_isJump;
                oPcWrite  = w_isJump;
            end
            default: begin
                oMemReq = 1'b0;
            end
        endcase
    end

    assign oIllegal = r_illegal;
    assign oBusErr  = r_busErr;
    assign oEcall   = r_ecall;
    assign oState   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Testbench for multicycle_control: two instances (timeout 4 + system on, timeout off + system off)
// checked every cycle against a behavioural model, plus literal sequence checks.
module tb_multicycle_control;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    // Output vector bit positions
    localparam int B_MEMREQ = 21, B_MEMRD = 20, B_MEMWR = 19, B_IRWR = 18, B_PCWR = 17;
    localparam int B_PCSRC = 16, B_ALUOP = 13, B_SRC1 = 12, B_SRC2 = 11, B_LUI = 10;
    localparam int B_M2R = 9, B_REGWR = 8, B_BRANCH = 7, B_JUMP = 6;
    localparam int B_ILL = 5, B_BUS = 4, B_ECALL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ack = 1'b0;
    logic       clr = 1'b0;
    logic [6:0] opcode = 7'd0;
    wire [21:0] aVec;
    wire [21:0] bVec;

    int nChecks = 0;
    int nFail   = 0;
    logic [21:0] seen [0:7];

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4), .ENABLE_SYSTEM(1)) dutA (
        .iClk(clk), .iRst(rst), .iOpcode(opcode), .iMemAck(ack), .iTrapClr(clr),
        .oMemReq(aVec[21]), .oMemRd(aVec[20]), .oMemWr(aVec[19]), .oIrWrite(aVec[18]),
        .oPcWrite(aVec[17]), .oPcSrc(aVec[16]), .oAluOp(aVec[15:13]), .oAluSrc1(aVec[12]),
        .oAluSrc2(aVec[11]), .oLui(aVec[10]), .oMemtoReg(aVec[9]), .oRegWrite(aVec[8]),
        .oBranch(aVec[7]), .oJump(aVec[6]), .oIllegal(aVec[5]), .oBusErr(aVec[4]),
        .oEcall(aVec[3]), .oState(aVec[2:0])
    );

    multicycle_control #(.MEM_TIMEOUT(0), .ENABLE_SYSTEM(0)) dutB (
        .iClk(clk), .iRst(rst), .iOpcode(opcode), .iMemAck(ack), .iTrapClr(clr),
        .oMemReq(bVec[21]), .oMemRd(bVec[20]), .oMemWr(bVec[19]), .oIrWrite(bVec[18]),
        .oPcWrite(bVec[17]), .oPcSrc(bVec[16]), .oAluOp(bVec[15:13]), .oAluSrc1(bVec[12]),
        .oAluSrc2(bVec[11]), .oLui(bVec[10]), .oMemtoReg(bVec[9]), .oRegWrite(bVec[8]),
        .oBranch(bVec[7]), .oJump(bVec[6]), .oIllegal(bVec[5]), .oBusErr(bVec[4]),
        .oEcall(bVec[3]), .oState(bVec[2:0])
    );

    // Model: phase numbers are the published state codes
    typedef struct {
        int         phase;
        logic [6:0] op;
        int         waited;
        bit         ill;
        bit         bus;
        bit         ecall;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;
    bit   valid = 1'b0;

    function automatic bit isKnown(logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    endfunction

    function automatic logic [21:0] expOut(mdl_t m, logic a);
        logic [21:0] v;
        v = '0;
        case (m.phase)
            0: begin
                v[B_MEMREQ] = 1'b1; v[B_MEMRD] = 1'b1;
                v[B_IRWR] = a; v[B_PCWR] = a;
            end
            2: begin
                case (m.op)
                    OP_R:  v[B_ALUOP +: 3] = 3'b010;
                    OP_I:  begin v[B_ALUOP +: 3] = 3'b011; v[B_SRC2] = 1'b1; end
                    OP_LD, OP_ST: v[B_SRC2] = 1'b1;
                    OP_BR: begin
                        v[B_ALUOP +: 3] = 3'b001; v[B_BRANCH] = 1'b1;
                        v[B_PCSRC] = 1'b1; v[B_PCWR] = 1'b1;
                    end
                    OP_LUI:   begin v[B_LUI] = 1'b1; v[B_SRC2] = 1'b1; end
                    OP_AUIPC: begin v[B_SRC1] = 1'b1; v[B_SRC2] = 1'b1; end
                    OP_JAL:   begin v[B_SRC1] = 1'b1; v[B_SRC2] = 1'b1; v[B_JUMP] = 1'b1; end
                    OP_JALR:  begin v[B_SRC2] = 1'b1; v[B_JUMP] = 1'b1; end
                    default: ;
                endcase
            end
            3: begin
                v[B_MEMREQ] = 1'b1; v[B_SRC2] = 1'b1;
                v[B_MEMRD] = (m.op == OP_LD); v[B_MEMWR] = (m.op == OP_ST);
            end
            4: begin
                v[B_REGWR] = 1'b1; v[B_M2R] = (m.op == OP_LD);
                if (m.op == OP_JAL || m.op == OP_JALR) begin
                    v[B_JUMP] = 1'b1; v[B_PCSRC] = 1'b1; v[B_PCWR] = 1'b1;
                end
            end
            default: ;
        endcase
        v[B_ILL] = m.ill; v[B_BUS] = m.bus; v[B_ECALL] = m.ecall;
        v[2:0] = m.phase[2:0];
        return v;
    endfunction

    function automatic mdl_t advance(mdl_t m, logic r, logic [6:0] op, logic a, logic c,
                                     int tmo, bit sys);
        mdl_t n;
        n = m;
        if (r) begin
            n.phase = 0; n.op = '0; n.waited = 0; n.ill = 0; n.bus = 0; n.ecall = 0;
            return n;
        end
        case (m.phase)
            0, 3: begin
                if (a) begin
                    if (m.phase == 0)       n.phase = 1;
                    else if (m.op == OP_LD) n.phase = 4;
                    else                    n.phase = 0;
                end else if (tmo != 0 && m.waited + 1 >= tmo) begin
                    n.phase = 5; n.bus = 1;
                end
            end
            1: begin
                n.op = op;
                if (isKnown(op))              n.phase = 2;
                else if (sys && op == OP_SYS) begin n.phase = 5; n.ecall = 1; end
                else                          begin n.phase = 5; n.ill = 1; end
            end
            2: begin
                if (m.op == OP_LD || m.op == OP_ST) n.phase = 3;
                else if (m.op == OP_BR)             n.phase = 0;
                else                                n.phase = 4;
            end
            4: n.phase = 0;
            5: if (c) begin n.phase = 0; n.ill = 0; n.bus = 0; n.ecall = 0; end
            default: n.phase = 0;
        endcase
        n.waited = (n.phase == m.phase && (m.phase == 0 || m.phase == 3)) ? m.waited + 1 : 0;
        return n;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) valid = 1'b1;
        ma = advance(ma, rst, opcode, ack, clr, 4, 1'b1);
        mb = advance(mb, rst, opcode, ack, clr, 0, 1'b0);
    end

    always @(negedge clk) begin
        if (valid) begin
            check("modelA", {10'd0, aVec}, {10'd0, expOut(ma, ack)});
            check("modelB", {10'd0, bVec}, {10'd0, expOut(mb, ack)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; ack = 1'b0; clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Drives ack per cycle from ackPat and checks dutA's state against expSt (3 bits per cycle)
    task automatic runSeq(string name, int n, logic [23:0] expSt, logic [7:0] ackPat);
        for (int i = 0; i < n; i++) begin
            ack = ackPat[i];
            @(negedge clk);
            seen[i] = aVec;
            check($sformatf("%s_st%0d", name, i), {29'd0, aVec[2:0]}, {29'd0, expSt[3*i +: 3]});
            step();
        end
    endtask

    function automatic logic [6:0] pickOp();
        logic [6:0] tbl [0:9];
        int r;
        tbl = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYS};
        r = $urandom_range(0, 11);
        if (r < 10) return tbl[r];
        return 7'($urandom);
    endfunction

    initial begin
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {29'd0, aVec[2:0]}, 32'd0);
        check("reset_fetch_req", {30'd0, aVec[B_MEMREQ -: 2]}, 32'd3);
        check("reset_flags", {29'd0, aVec[B_ILL -: 3]}, 32'd0);
        step();

        doReset(); opcode = OP_R;
        runSeq("add", 5, {9'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 8'hFF);
        check("add_exec_aluop", {29'd0, seen[2][B_ALUOP +: 3]}, 32'd2);
        check("add_exec_regwr", {31'd0, seen[2][B_REGWR]}, 32'd0);
        check("add_wb_regwr", {31'd0, seen[3][B_REGWR]}, 32'd1);

        doReset(); opcode = OP_LD;
        runSeq("lw", 7, {3'd0, 3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0}, 8'b0010_0001);
        check("lw_mem_rd", {29'd0, seen[3][B_MEMRD], seen[4][B_MEMRD], seen[5][B_MEMRD]}, 32'd7);
        check("lw_wb_m2r_regwr", {30'd0, seen[6][B_M2R], seen[6][B_REGWR]}, 32'd3);

        doReset(); opcode = OP_ST;
        runSeq("sw", 5, {9'd0, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0}, 8'hFF);
        check("sw_mem_wr", {30'd0, seen[2][B_MEMWR], seen[3][B_MEMWR]}, 32'd1);

        doReset(); opcode = OP_BR;
        runSeq("beq", 4, {12'd0, 3'd0, 3'd2, 3'd1, 3'd0}, 8'hFF);
        check("beq_exec_strobes", {29'd0, seen[2][B_BRANCH], seen[2][B_PCSRC], seen[2][B_PCWR]}, 32'd7);
        check("beq_exec_aluop", {29'd0, seen[2][B_ALUOP +: 3]}, 32'd1);

        doReset(); opcode = OP_JAL;
        runSeq("jal", 5, {9'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 8'hFF);
        check("jal_wb_strobes", {29'd0, seen[3][B_JUMP], seen[3][B_REGWR], seen[3][B_PCWR]}, 32'd7);

        doReset(); opcode = 7'd0;
        runSeq("ill", 3, {15'd0, 3'd5, 3'd1, 3'd0}, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("ill_held%0d", i), {30'd0, aVec[B_ILL], aVec[B_ECALL]}, 32'd2);
            step();
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        check("ill_cleared", {28'd0, aVec[B_ILL], aVec[2:0]}, 32'd0);
        step();

        doReset(); opcode = OP_SYS;
        runSeq("sys", 3, {15'd0, 3'd5, 3'd1, 3'd0}, 8'hFF);
        @(negedge clk);
        check("sys_a_ecall", {30'd0, aVec[B_ECALL], aVec[B_ILL]}, 32'd2);
        check("sys_b_illegal", {30'd0, bVec[B_ECALL], bVec[B_ILL]}, 32'd1);
        step();

        doReset(); opcode = OP_R;
        runSeq("tmo", 5, {9'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0}, 8'h00);
        check("tmo_buserr", {31'd0, seen[4][B_BUS]}, 32'd1);
        check("tmo_b_no_timeout", {29'd0, bVec[2:0]}, 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        runSeq("ack4", 5, {9'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0}, 8'b0000_1000);

        doReset(); opcode = OP_LD;
        runSeq("rstmem", 4, {12'd0, 3'd3, 3'd2, 3'd1, 3'd0}, 8'b0000_0001);
        rst = 1'b1; ack = 1'b1;
        step();
        rst = 1'b0; ack = 1'b0;
        @(negedge clk);
        check("rstmem_state_flags", {26'd0, aVec[B_ILL -: 3], aVec[2:0]}, 32'd0);
        step();

        for (int k = 0; k < 4000; k++) begin
            int ackPct;
            ackPct = 30 + (k / 500) * 10;
            rst    = ($urandom_range(0, 299) == 0);
            ack    = ($urandom_range(0, 99) < ackPct);
            clr    = ($urandom_range(0, 3) == 0);
            opcode = pickOp();
            step();
        end
        rst = 1'b0; ack = 1'b0; clr = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
